// File: rtl/store_queue_ctrl.sv
// Store queue between a 2-wide commit stage and a single dmem write port.
// Latency: a store accepted at edge N can write at the earliest in cycle N+1.
// Backpressure: st_ready needs room for two stores; mem_busy holds the head entry.
// Optional: define STORE_FWD_EN to add load-to-store forwarding ports.

package store_queue_pkg;
    typedef logic [2:0] ldst_mode_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        ldst_mode_t  mode;
    } sq_entry_t;
endpackage

module store_queue_ctrl
    import store_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            st_valid,
    input  logic [1:0][31:0]      st_addr,
    input  logic [1:0][31:0]      st_data,
    input  ldst_mode_t [1:0]      st_mode,
    output logic                  st_ready,
    input  logic                  mem_busy,
    output logic                  we,
    output logic [31:0]           wa,
    output logic [31:0]           wd,
    output ldst_mode_t            wm,
    output logic [CW-1:0]         count,
    output logic                  empty
`ifdef STORE_FWD_EN
    ,
    input  logic [1:0][31:0]      ld_addr,
    output logic [1:0]            fwd_hit,
    output logic [1:0][31:0]      fwd_data
`endif
);

    localparam int PW = $clog2(DEPTH);

    sq_entry_t       ent_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic            accept;
    logic            both_vld;
    logic [1:0]      n_enq;
    sq_entry_t       lane_ent [2];
    sq_entry_t       slot0_ent;

    // Ready is a function of the registered count only, so it never depends on mem_busy.
    assign st_ready = (count_q <= CW'(DEPTH - 2));
    assign empty    = (count_q == '0);
    assign count    = count_q;

    // The head entry is always presented; the write only fires when the port is free.
    assign we = !empty && !mem_busy;
    assign wa = ent_q[head_q].addr;
    assign wd = ent_q[head_q].data;
    assign wm = ent_q[head_q].mode;

    // Enqueue decode: the older valid lane always lands at tail, lane 1 follows it.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            lane_ent[l].addr = st_addr[l];
            lane_ent[l].data = st_data[l];
            lane_ent[l].mode = st_mode[l];
        end
        accept    = st_ready && (st_valid != 2'b00);
        both_vld  = (st_valid == 2'b11);
        n_enq     = !accept ? 2'd0 : (both_vld ? 2'd2 : 2'd1);
        slot0_ent = st_valid[0] ? lane_ent[0] : lane_ent[1];
    end

    // Next pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_comb begin
        head_d  = head_q + PW'(we);
        tail_d  = tail_q + PW'(n_enq);
        count_d = count_q + CW'(n_enq) - CW'(we);
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload storage; contents are only meaningful under a valid count.
    always_ff @(posedge clk) begin
        if (accept) begin
            ent_q[tail_q] <= slot0_ent;
            if (both_vld) begin
                ent_q[tail_q + PW'(1)] <= lane_ent[1];
            end
        end
    end

`ifdef STORE_FWD_EN
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    fwd_idx;

    // Per-entry valid bits; drain clears the head, enqueue marks the tail slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (we) begin
                valid_q[head_q] <= 1'b0;
            end
            if (accept) begin
                valid_q[tail_q] <= 1'b1;
                if (both_vld) begin
                    valid_q[tail_q + PW'(1)] <= 1'b1;
                end
            end
        end
    end

    // Walk oldest to youngest so the last word-address match wins.
    always_comb begin
        fwd_hit  = '0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < DEPTH; i++) begin
                fwd_idx = head_q + PW'(i);
                if (valid_q[fwd_idx] && (ent_q[fwd_idx].addr[31:2] == ld_addr[l][31:2])) begin
                    fwd_hit[l]  = 1'b1;
                    fwd_data[l] = ent_q[fwd_idx].data;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_store_queue_ctrl.sv
// Directed bench for store_queue_ctrl (DEPTH=4) with a simple dmem model.
// Inputs change on the falling edge; outputs are checked 1ns later.
// Each check is an immediate assertion that counts and reports failures.

module tb_store_queue_ctrl;
    import store_queue_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [1:0]       st_valid;
    logic [1:0][31:0] st_addr;
    logic [1:0][31:0] st_data;
    ldst_mode_t [1:0] st_mode;
    logic             st_ready;
    logic             mem_busy;
    logic             we;
    logic [31:0]      wa;
    logic [31:0]      wd;
    ldst_mode_t       wm;
    logic [2:0]       count;
    logic             empty;
`ifdef STORE_FWD_EN
    logic [1:0][31:0] ld_addr;
    logic [1:0]       fwd_hit;
    logic [1:0][31:0] fwd_data;
`endif

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int wr_mark;
    logic [31:0] dmem [256];

    store_queue_ctrl #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_mode  (st_mode),
        .st_ready (st_ready),
        .mem_busy (mem_busy),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .wm       (wm),
        .count    (count),
        .empty    (empty)
`ifdef STORE_FWD_EN
        ,
        .ld_addr  (ld_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: commits a write on each rising edge where we is high.
    always @(posedge clk) begin
        if (we === 1'b1) begin
            dmem[wa[9:2]] <= wd;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic lane(input int l, input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
        st_addr[l] = a;
        st_data[l] = d;
        st_mode[l] = m;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        rst_n    = 1'b0;
        st_valid = 2'b00;
        st_addr  = '0;
        st_data  = '0;
        st_mode  = '0;
        mem_busy = 1'b0;
`ifdef STORE_FWD_EN
        ld_addr  = '0;
`endif
        #1;
        chk("rst_we", we, 0);
        chk("rst_ready", st_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
`ifdef STORE_FWD_EN
        chk("rst_fwd_hit", fwd_hit, 0);
`endif
        step(); step();
        rst_n = 1'b1;

        // Reset while draining with three entries queued.
        step();
        mem_busy = 1'b1;
        st_valid = 2'b11; lane(0, 32'h40, 32'h11, 3'd0); lane(1, 32'h44, 32'h12, 3'd0);
        step();
        st_valid = 2'b01; lane(0, 32'h48, 32'h13, 3'd0);
        step();
        st_valid = 2'b00; mem_busy = 1'b0;
        #1;
        chk("t1_count3", count, 3);
        chk("t1_we_pre", we, 1);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_we", we, 0);
        chk("t1_rst_count", count, 0);
        chk("t1_rst_empty", empty, 1);
        chk("t1_rst_ready", st_ready, 1);
        wr_mark = wr_cnt;
        step();
        rst_n = 1'b1;
        step(); step();
        chk("t1_no_write", wr_cnt - wr_mark, 0);
        chk("t1_dmem16", dmem[16], 0);

        // Dual store to the same word: lane 0 then lane 1.
        step();
        st_valid = 2'b11; lane(0, 32'h10, 32'hA, 3'd1); lane(1, 32'h10, 32'hB, 3'd2);
        #1;
        chk("t2_we_empty", we, 0);
        step();
        st_valid = 2'b00;
        #1;
        chk("t2_count2", count, 2);
        chk("t2_we0", we, 1);
        chk("t2_wa0", wa, 32'h10);
        chk("t2_wd0", wd, 32'hA);
        chk("t2_wm0", wm, 1);
        step(); #1;
        chk("t2_we1", we, 1);
        chk("t2_wd1", wd, 32'hB);
        chk("t2_wm1", wm, 2);
        step(); #1;
        chk("t2_empty", empty, 1);
        chk("t2_we_done", we, 0);
        chk("t2_dmem4", dmem[4], 32'hB);

        // Fill to DEPTH, hold a third pair, then drain in order.
        step();
        mem_busy = 1'b1;
        st_valid = 2'b11; lane(0, 32'h100, 32'h31, 3'd0); lane(1, 32'h104, 32'h32, 3'd0);
        step();
        st_valid = 2'b11; lane(0, 32'h108, 32'h33, 3'd0); lane(1, 32'h10C, 32'h34, 3'd0);
        #1;
        chk("t3_ready_c2", st_ready, 1);
        step();
        st_valid = 2'b11; lane(0, 32'h110, 32'h35, 3'd0); lane(1, 32'h114, 32'h36, 3'd0);
        #1;
        chk("t3_count4", count, 4);
        chk("t3_ready_full", st_ready, 0);
        chk("t3_we_busy", we, 0);
        step();
        mem_busy = 1'b0;
        #1;
        chk("t3_held_count", count, 4);
        chk("t3_wd31", wd, 32'h31);
        chk("t3_we_go", we, 1);
        step(); #1;
        chk("t3_count3", count, 3);
        chk("t3_ready_c3", st_ready, 0);
        chk("t3_wd32", wd, 32'h32);
        step(); #1;
        chk("t3_count2", count, 2);
        chk("t3_ready_again", st_ready, 1);
        chk("t3_wd33", wd, 32'h33);
        step();
        st_valid = 2'b00;
        #1;
        chk("t3_count_enq_deq", count, 3);
        chk("t3_wd34", wd, 32'h34);
        step(); #1;
        chk("t3_wd35", wd, 32'h35);
        chk("t3_wa110", wa, 32'h110);
        step(); #1;
        chk("t3_wd36", wd, 32'h36);
        step(); #1;
        chk("t3_empty", empty, 1);
        chk("t3_dmem_last", dmem[69], 32'h36);

        // Pointer wrap with simultaneous enqueue and drain.
        mem_busy = 1'b1;
        st_valid = 2'b11; lane(0, 32'h200, 32'h41, 3'd0); lane(1, 32'h204, 32'h42, 3'd0);
        step();
        st_valid = 2'b01; lane(0, 32'h208, 32'h43, 3'd0);
        step();
        st_valid = 2'b00; mem_busy = 1'b0;
        #1;
        chk("t4_wd41", wd, 32'h41);
        step(); #1;
        chk("t4_wd42", wd, 32'h42);
        step();
        st_valid = 2'b11; lane(0, 32'h20C, 32'h44, 3'd0); lane(1, 32'h210, 32'h45, 3'd0);
        #1;
        chk("t4_count1", count, 1);
        chk("t4_wd43", wd, 32'h43);
        step();
        st_valid = 2'b00;
        #1;
        chk("t4_count_net", count, 2);
        chk("t4_wa44", wa, 32'h20C);
        chk("t4_wd44", wd, 32'h44);
        step(); #1;
        chk("t4_wa45", wa, 32'h210);
        chk("t4_wd45", wd, 32'h45);
        step(); #1;
        chk("t4_empty", empty, 1);
        chk("t4_dmem_wrap", dmem[132], 32'h45);

        // Lane-1-only stores with mem_busy toggling.
        mem_busy = 1'b1;
        st_valid = 2'b10; lane(1, 32'h300, 32'h51, 3'd4);
        #1;
        chk("t5_we_empty", we, 0);
        step();
        mem_busy = 1'b0;
        st_valid = 2'b10; lane(1, 32'h304, 32'h52, 3'd5);
        #1;
        chk("t5_we_a", we, 1);
        chk("t5_wa_a", wa, 32'h300);
        chk("t5_wm_a", wm, 4);
        step();
        mem_busy = 1'b1; st_valid = 2'b00;
        #1;
        chk("t5_count", count, 1);
        chk("t5_we_hold", we, 0);
        chk("t5_wa_hold", wa, 32'h304);
        chk("t5_wd_hold", wd, 32'h52);
        step();
        mem_busy = 1'b0;
        #1;
        chk("t5_we_b", we, 1);
        chk("t5_wd_b", wd, 32'h52);
        step();
        mem_busy = 1'b1;
        #1;
        chk("t5_empty", empty, 1);
        chk("t5_dmem192", dmem[192], 32'h51);
        chk("t5_dmem193", dmem[193], 32'h52);
        chk("total_writes", wr_cnt, 15);

`ifdef STORE_FWD_EN
        // Forwarding picks the youngest match on the word address.
        st_valid = 2'b01; lane(0, 32'h20, 32'h1, 3'd0);
        step();
        st_valid = 2'b01; lane(0, 32'h20, 32'h2, 3'd0);
        step();
        st_valid = 2'b00;
        ld_addr[0] = 32'h23; ld_addr[1] = 32'h24;
        #1;
        chk("t6_hit0", fwd_hit[0], 1);
        chk("t6_data0", fwd_data[0], 32'h2);
        chk("t6_hit1", fwd_hit[1], 0);
        mem_busy = 1'b0;
        step(); step(); #1;
        chk("t6_drained_hit", fwd_hit[0], 0);
`endif

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
